// File: rtl/reg_file_wb.sv
// reg_file_wb: MIPS register file with same-cycle write-back bypass and a
// pending-write scoreboard that raises a decode stall on RAW/WAW hazards.
module reg_file_wb #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  input  logic              rs_used,
  input  logic              rt_used,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              iss_valid,
  input  logic [4:0]        iss_dest,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              stall,
  output logic [NREG-1:0]   busy
);

  logic [DATA_W-1:0] r_regs [NREG];
  logic [NREG-1:0]   r_busy;
  logic [NREG-1:0]   w_busy_set;
  logic [NREG-1:0]   w_busy_clr;
  logic [NREG-1:0]   w_busy_nxt;
  logic              w_rs_byp;
  logic              w_rt_byp;
  logic              w_dest_byp;
  logic              w_rs_hz;
  logic              w_rt_hz;
  logic              w_waw_hz;
  logic              w_stall;

  // A write-back matching a source/destination this cycle both forwards data
  // and retires the pending bit, so it also cancels the matching hazard.
  always_comb begin
    w_rs_byp   = wr_en && (wr_addr == rs_addr);
    w_rt_byp   = wr_en && (wr_addr == rt_addr);
    w_dest_byp = wr_en && (wr_addr == iss_dest);
  end

  // Combinational source reads: $zero and reset force 0, otherwise bypass or array.
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (!reset && (rs_addr != '0))
      rs_data = w_rs_byp ? wr_data : r_regs[rs_addr];
    if (!reset && (rt_addr != '0))
      rt_data = w_rt_byp ? wr_data : r_regs[rt_addr];
  end

  // RAW on either used source, WAW on the issuing destination; masked in reset.
  always_comb begin
    w_rs_hz  = rs_used   && r_busy[rs_addr]  && !w_rs_byp;
    w_rt_hz  = rt_used   && r_busy[rt_addr]  && !w_rt_byp;
    w_waw_hz = iss_valid && r_busy[iss_dest] && !w_dest_byp;
    w_stall  = !reset && (w_rs_hz || w_rt_hz || w_waw_hz);
    stall    = w_stall;
  end

  // Scoreboard next state: accepted issue sets, write-back clears, set wins.
  always_comb begin
    w_busy_set = '0;
    w_busy_clr = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      w_busy_set[i] = iss_valid && !w_stall && (iss_dest == 5'(i));
      w_busy_clr[i] = wr_en && (wr_addr == 5'(i));
    end
    w_busy_nxt    = (r_busy & ~w_busy_clr) | w_busy_set;
    w_busy_nxt[0] = 1'b0;
  end

  // Register array: cleared on reset, write-back to $zero dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++)
        r_regs[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  // Pending-write bits: reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (reset)
      r_busy <= '0;
    else
      r_busy <= w_busy_nxt;
  end

  assign busy = r_busy;

endmodule

// File: tb/tb_reg_file_wb.sv
// Testbench for reg_file_wb: table-driven cycle vectors plus hand sequences,
// expected outputs queued when a cycle is driven and checked when sampled.
module tb_reg_file_wb;

  logic        clk;
  logic        reset;
  logic [4:0]  rs_addr, rt_addr;
  logic        rs_used, rt_used;
  logic [31:0] rs_data, rt_data;
  logic        iss_valid;
  logic [4:0]  iss_dest;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        stall;
  logic [31:0] busy;

  reg_file_wb #(.DATA_W(32), .NREG(32)) dut (
    .clk(clk), .reset(reset),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_used(rs_used), .rt_used(rt_used),
    .rs_data(rs_data), .rt_data(rt_data),
    .iss_valid(iss_valid), .iss_dest(iss_dest),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .stall(stall), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        rst;
    logic [4:0]  rs, rt;
    logic        ru, tu, iv;
    logic [4:0]  id;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] ers, ert;
    logic        est;
    logic        cb;
    logic [31:0] eb;
  } vec_t;

  typedef struct {
    string       nm;
    logic [31:0] ers, ert;
    logic        est;
    logic        cb;
    logic [31:0] eb;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[$];
  int   n_err = 0;
  int   n_chk = 0;

  function automatic vec_t v(string nm, logic rst, logic [4:0] rs, logic [4:0] rt,
                             logic ru, logic tu, logic iv, logic [4:0] id,
                             logic we, logic [4:0] wa, logic [31:0] wd,
                             logic [31:0] ers, logic [31:0] ert, logic est,
                             logic cb, logic [31:0] eb);
    vec_t x;
    x.nm = nm; x.rst = rst; x.rs = rs; x.rt = rt; x.ru = ru; x.tu = tu;
    x.iv = iv; x.id = id; x.we = we; x.wa = wa; x.wd = wd;
    x.ers = ers; x.ert = ert; x.est = est; x.cb = cb; x.eb = eb;
    return x;
  endfunction

  task automatic chk(input string nm, input string what,
                     input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s.%s: got %h, required %h", nm, what, act, req);
    end
  endtask

  // Drive one cycle after the falling edge, sample before the next rising edge.
  task automatic step(input vec_t x);
    exp_t e;
    @(negedge clk);
    reset = x.rst; rs_addr = x.rs; rt_addr = x.rt; rs_used = x.ru; rt_used = x.tu;
    iss_valid = x.iv; iss_dest = x.id; wr_en = x.we; wr_addr = x.wa; wr_data = x.wd;
    e.nm = x.nm; e.ers = x.ers; e.ert = x.ert; e.est = x.est; e.cb = x.cb; e.eb = x.eb;
    exp_q.push_back(e);
    #2;
    e = exp_q.pop_front();
    chk(e.nm, "rs_data", rs_data, e.ers);
    chk(e.nm, "rt_data", rt_data, e.ert);
    chk(e.nm, "stall", {31'd0, stall}, {31'd0, e.est});
    if (e.cb) chk(e.nm, "busy", busy, e.eb);
  endtask

  initial begin
    reset = 1'b1; rs_addr = '0; rt_addr = '0; rs_used = 1'b0; rt_used = 1'b0;
    iss_valid = 1'b0; iss_dest = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;

    //           name        rst rs rt ru tu iv id we wa wd             ers           ert           st cb busy
    tbl.push_back(v("rst",      1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0));
    tbl.push_back(v("wr5_byp",  0, 5, 0, 0, 0, 0, 0, 1, 5, 32'h1234,     32'h1234,     32'h0,        0, 1, 32'h0));
    tbl.push_back(v("rd5",      0, 5, 5, 0, 0, 0, 0, 0, 0, 32'h0,        32'h1234,     32'h1234,     0, 1, 32'h0));
    tbl.push_back(v("rst_hold", 1, 5, 5, 1, 1, 1, 6, 1, 6, 32'hAAAA,     32'h0,        32'h0,        0, 1, 32'h0));
    tbl.push_back(v("post_rst", 0, 6, 5, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 32'h0));
    tbl.push_back(v("zero_wr",  0, 0, 0, 0, 0, 1, 0, 1, 0, 32'hFFFFFFFF, 32'h0,        32'h0,        0, 1, 32'h0));
    tbl.push_back(v("zero_rd",  0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 32'h0));
    tbl.push_back(v("byp7",     0, 7, 7, 0, 0, 0, 0, 1, 7, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 0, 1, 32'h0));
    tbl.push_back(v("rd7",      0, 7, 7, 0, 0, 0, 0, 0, 0, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 0, 1, 32'h0));
    tbl.push_back(v("waw_iss",  0, 0, 0, 0, 0, 1, 9, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 32'h0));
    tbl.push_back(v("waw_st1",  0, 0, 0, 0, 0, 1, 9, 0, 0, 32'h0,        32'h0,        32'h0,        1, 1, 32'h200));
    tbl.push_back(v("waw_st2",  0, 0, 0, 0, 0, 1, 9, 0, 0, 32'h0,        32'h0,        32'h0,        1, 1, 32'h200));
    tbl.push_back(v("set_win",  0, 9, 0, 0, 0, 1, 9, 1, 9, 32'h99,       32'h99,       32'h0,        0, 1, 32'h200));
    tbl.push_back(v("waw_held", 0, 9, 9, 0, 0, 0, 0, 0, 0, 32'h0,        32'h99,       32'h99,       0, 1, 32'h200));
    tbl.push_back(v("rt_hz",    0, 9, 9, 0, 1, 0, 0, 0, 0, 32'h0,        32'h99,       32'h99,       1, 1, 32'h200));
    tbl.push_back(v("rt_wb",    0, 9, 9, 0, 1, 0, 0, 1, 9, 32'h1,        32'h1,        32'h1,        0, 1, 32'h200));
    tbl.push_back(v("rt_done",  0, 9, 9, 0, 1, 0, 0, 0, 0, 32'h0,        32'h1,        32'h1,        0, 1, 32'h0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // RAW on the JAL link register: hold three cycles, then clear by write-back.
    step(v("jal_iss",  0, 0, 7, 0, 0, 1, 31, 0, 0, 32'h0, 32'h0, 32'hCAFEF00D, 0, 1, 32'h0));
    for (int k = 0; k < 3; k++)
      step(v("raw_hold", 0, 31, 7, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'hCAFEF00D, 1, 1, 32'h80000000));
    step(v("raw_wb",   0, 31, 7, 1, 0, 0, 0, 1, 31, 32'h00400008, 32'h00400008, 32'hCAFEF00D, 0, 1, 32'h80000000));
    step(v("raw_done", 0, 31, 7, 1, 0, 0, 0, 0, 0, 32'h0, 32'h00400008, 32'hCAFEF00D, 0, 1, 32'h0));

    // Two pending writes, a write committing under stall, then reset mid-flight.
    step(v("iss3",     0, 0, 0, 0, 0, 1, 3, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1, 32'h0));
    step(v("iss12",    0, 0, 0, 0, 0, 1, 12, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1, 32'h8));
    step(v("stall_wr", 0, 3, 20, 1, 0, 0, 0, 1, 20, 32'h2020, 32'h0, 32'h2020, 1, 1, 32'h1008));
    step(v("chk20",    0, 20, 3, 0, 0, 0, 0, 0, 0, 32'h0, 32'h2020, 32'h0, 0, 1, 32'h1008));
    step(v("mid_rst",  1, 3, 20, 1, 0, 1, 5, 1, 4, 32'h4444, 32'h0, 32'h0, 0, 1, 32'h1008));
    step(v("after_rst",0, 3, 20, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1, 32'h0));
    step(v("after2",   0, 7, 4, 1, 1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1, 32'h0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_file_wb.md
# reg_file_wb

Register file and write-back scoreboard for the MIPS datapath. It receives the 5-bit destination chosen by the write-back destination select (rd, rt, or 31 for JAL) together with the write-back data. It serves the two decode-stage source reads with same-cycle bypass. It tracks destinations of issued but not-yet-written instructions and raises a decode stall on RAW and WAW hazards.

## Interface
Parameters:
- DATA_W, 32, register width
- NREG, 32, register count (address width fixed at 5)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- rs_addr  in  5  source 1 read address
- rt_addr  in  5  source 2 read address
- rs_used  in  1  decoded instruction reads rs
- rt_used  in  1  decoded instruction reads rt
- rs_data  out  DATA_W  source 1 read data
- rt_data  out  DATA_W  source 2 read data
- iss_valid  in  1  decode is issuing an instruction that writes a register
- iss_dest  in  5  destination of issuing instruction (31 for JAL)
- wr_en  in  1  write-back strobe
- wr_addr  in  5  write-back destination
- wr_data  in  DATA_W  write-back value
- stall  out  1  hold decode this cycle
- busy  out  NREG  pending-write bit per register

## Operation
- Storage is regs[0..31]. regs[0] reads 0 always, and writes to address 0 are dropped.
- **Write:** on the edge with wr_en=1 and wr_addr≠0, regs[wr_addr] ← wr_data.
- **Read:** combinational.
  - If wr_en=1 and wr_addr==rs_addr≠0, rs_data = wr_data (bypass).
  - Otherwise rs_data = regs[rs_addr].
  - rt_data behaves identically.
- **Scoreboard:**
  - busy[i] is set on the edge when iss_valid=1, iss_dest=i≠0 and stall=0.
  - busy[i] is cleared on the edge when wr_en=1 and wr_addr=i.
  - If the same register is set and cleared in one cycle, set wins.
  - busy[0] is always 0.
- **Hazards:**
  - rs_hz = rs_used & busy[rs_addr] & ~(wr_en & wr_addr==rs_addr). rt_hz is defined the same way.
  - waw_hz = iss_valid & busy[iss_dest] & ~(wr_en & wr_addr==iss_dest).
  - stall = rs_hz | rt_hz | waw_hz, combinational.
- A stalled issue does not set busy. Decode re-presents the same inputs the next cycle.
- A write-back to a register whose busy bit is 0 is legal. It updates the register and leaves busy at 0.
- Writes and scoreboard are independent. A write while stall=1 still commits.

## Timing
- Reset: every regs[i]=0 and busy=0 on the first edge with reset=1. While reset=1, reads return 0, stall=0, and iss_valid and wr_en are ignored.
- Reset asserted mid-operation discards all pending busy bits. No write commits on the reset edge.
- Read latency is 0 cycles, combinational from address. A write is visible through bypass in the same cycle and from regs on the next cycle.
- Stall latency is 0 cycles. When a write-back clears the hazard in cycle N, stall deasserts in cycle N, and the consumer gets the bypassed value.
- Issue-to-busy: busy[d] rises one edge after an accepted issue. It falls one edge after the matching write-back, or stays 1 if re-issued the same cycle.

## Test plan
- **Reset:** write 0x1234 to $5, then assert reset 1 cycle → rs_addr=5 reads 0, busy=0, stall=0.
- **$zero:** wr_en, wr_addr=0, wr_data=0xFFFFFFFF → rs_addr=0 reads 0 in the same and next cycle. iss_dest=0 never sets busy.
- **Bypass:** wr_en, wr_addr=7, wr_data=0xCAFEF00D with rs_addr=rt_addr=7 → both outputs 0xCAFEF00D in that cycle and all later cycles.
- **RAW:**
  - Issue iss_dest=31 (JAL). Next cycle rs_used=1, rs_addr=31 → stall=1.
  - Hold 3 cycles, then write-back wr_addr=31, wr_data=0x00400008 → stall=0 that cycle, rs_data=0x00400008, busy[31]=0 next cycle.
- **WAW, set-wins:**
  - With busy[9]=1, issue iss_dest=9 → stall=1 and busy unchanged.
  - Then drive wr_en to 9 with iss_valid to 9 in the same cycle → stall=0, and busy[9] stays 1.
- **Reset mid-flight:** busy[3]=1 and busy[12]=1, assert reset 1 cycle → busy=0. A subsequent rs_addr=3 read with rs_used=1 gives stall=0.
